// File: rtl/wback_regfile_if.sv
// rtl/wback_regfile_if.sv - W-stage inputs, decode read ports and status outputs of the writeback/regfile block
interface wback_regfile_if;
  logic [1:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic [3:0]  d_srcA;
  logic [3:0]  d_srcB;
  logic [63:0] d_rvalA;
  logic [63:0] d_rvalB;
  logic [1:0]  Stat;
  logic        halted;
  logic [63:0] icount;

  modport master (
    output W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, d_srcA, d_srcB,
    input  d_rvalA, d_rvalB, Stat, halted, icount
  );

  modport slave (
    input  W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, d_srcA, d_srcB,
    output d_rvalA, d_rvalB, Stat, halted, icount
  );
endinterface

// File: rtl/wback_regfile.sv
// rtl/wback_regfile.sv - Y86-64 writeback stage, 15x64 register file, sticky status and retire counter
module wback_regfile (
  input  logic            clk,
  input  logic            rst_n,
  wback_regfile_if.slave  wb
);

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [3:0] I_NOP    = 4'h1;

  logic [63:0] regs [0:14];
  logic [1:0]  stat_q;
  logic        halted_q;
  logic [63:0] icount_q;
  logic        commit;
  logic        retire;

  assign commit = (wb.W_stat == STAT_AOK) && !halted_q;
  assign retire = !halted_q &&
                  (((wb.W_stat == STAT_AOK) && (wb.W_icode != I_NOP)) ||
                   (wb.W_stat == STAT_HLT));

  // dstM is checked first so that a dstE/dstM collision writes valM (popq %rsp)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) regs[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < 15; i++) begin
        if (wb.W_dstM == 4'(i))
          regs[i] <= wb.W_valM;
        else if (wb.W_dstE == 4'(i))
          regs[i] <= wb.W_valE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q   <= STAT_AOK;
      halted_q <= 1'b0;
      icount_q <= '0;
    end else if (!halted_q) begin
      if (wb.W_stat != STAT_AOK) begin
        stat_q   <= wb.W_stat;
        halted_q <= 1'b1;
      end
      if (retire)
        icount_q <= icount_q + 64'd1;
    end
  end

  always_comb begin
    wb.d_rvalA = '0;
    wb.d_rvalB = '0;
    if (wb.d_srcA != RNONE) wb.d_rvalA = regs[wb.d_srcA];
    if (wb.d_srcB != RNONE) wb.d_rvalB = regs[wb.d_srcB];
  end

  assign wb.Stat   = stat_q;
  assign wb.halted = halted_q;
  assign wb.icount = icount_q;

endmodule

// File: tb/tb_wback_regfile.sv
// tb/tb_wback_regfile.sv - directed-vector bench for wback_regfile
module tb_wback_regfile;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  wback_regfile_if wbi ();

  wback_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wbi.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_w(input logic [1:0] st, input logic [3:0] ic,
                         input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
    wbi.W_stat  = st;
    wbi.W_icode = ic;
    wbi.W_dstE  = de;
    wbi.W_valE  = ve;
    wbi.W_dstM  = dm;
    wbi.W_valM  = vm;
  endtask

  // one edge, then park a bubble in W so no further edge commits anything
  task automatic step();
    @(posedge clk);
    #1;
    drive_w(2'b00, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] b);
    wbi.d_srcA = a;
    wbi.d_srcB = b;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive_w(2'b00, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    rd(4'd0, 4'd14);
    chk("rst_rvalA", wbi.d_rvalA, 64'h0);
    chk("rst_rvalB", wbi.d_rvalB, 64'h0);
    chk("rst_stat", 64'(wbi.Stat), 64'h0);
    chk("rst_halted", 64'(wbi.halted), 64'h0);
    chk("rst_icount", wbi.icount, 64'h0);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    drive_w(2'b00, 4'h5, 4'd3, 64'h11, 4'd7, 64'h22);
    rd(4'd3, 4'd7);
    chk("dual_pre_r3", wbi.d_rvalA, 64'h0);
    chk("dual_pre_r7", wbi.d_rvalB, 64'h0);
    step();
    rd(4'd3, 4'd7);
    chk("dual_r3", wbi.d_rvalA, 64'h11);
    chk("dual_r7", wbi.d_rvalB, 64'h22);
    chk("dual_icount", wbi.icount, 64'd1);

    @(negedge clk);
    drive_w(2'b00, 4'h6, 4'd14, 64'hDEAD_BEEF_0000_0001, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    rd(4'd0, 4'd14);
    chk("edge_r0", wbi.d_rvalA, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("edge_r14", wbi.d_rvalB, 64'hDEAD_BEEF_0000_0001);
    rd(4'hF, 4'hF);
    chk("rnone_rvalA", wbi.d_rvalA, 64'h0);
    chk("rnone_rvalB", wbi.d_rvalB, 64'h0);
    chk("bubble_not_counted", wbi.icount, 64'd2);

    @(negedge clk);
    drive_w(2'b00, 4'hB, 4'd4, 64'hAAAA, 4'd4, 64'hBBBB);
    step();
    rd(4'd4, 4'd3);
    chk("collide_r4", wbi.d_rvalA, 64'hBBBB);
    chk("collide_icount", wbi.icount, 64'd3);

    @(negedge clk);
    drive_w(2'b00, 4'h6, 4'hF, 64'h1234, 4'hF, 64'h5678);
    step();
    rd(4'd4, 4'd3);
    chk("rnone_r4", wbi.d_rvalA, 64'hBBBB);
    chk("rnone_r3", wbi.d_rvalB, 64'h11);
    chk("rnone_icount", wbi.icount, 64'd4);

    @(negedge clk);
    drive_w(2'b01, 4'h0, 4'hF, 64'h0, 4'hF, 64'h0);
    step();
    chk("hlt_stat", 64'(wbi.Stat), 64'h1);
    chk("hlt_halted", 64'(wbi.halted), 64'h1);
    chk("hlt_icount", wbi.icount, 64'd5);

    @(negedge clk);
    drive_w(2'b00, 4'h6, 4'd2, 64'h5, 4'hF, 64'h0);
    step();
    rd(4'd2, 4'd3);
    chk("frozen_r2", wbi.d_rvalA, 64'h0);
    chk("frozen_icount", wbi.icount, 64'd5);
    chk("frozen_stat", 64'(wbi.Stat), 64'h1);

    // asynchronous reset between edges, checked before the next posedge
    @(negedge clk);
    rd(4'd3, 4'd14);
    rst_n = 1'b0;
    #1;
    chk("async_r3", wbi.d_rvalA, 64'h0);
    chk("async_r14", wbi.d_rvalB, 64'h0);
    chk("async_stat", 64'(wbi.Stat), 64'h0);
    chk("async_halted", 64'(wbi.halted), 64'h0);
    chk("async_icount", wbi.icount, 64'h0);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_w(2'b10, 4'h5, 4'hF, 64'h0, 4'd1, 64'h9);
    step();
    rd(4'd1, 4'hF);
    chk("adr_r1", wbi.d_rvalA, 64'h0);
    chk("adr_stat", 64'(wbi.Stat), 64'h2);
    chk("adr_halted", 64'(wbi.halted), 64'h1);
    chk("adr_icount", wbi.icount, 64'h0);

    @(negedge clk);
    drive_w(2'b11, 4'h6, 4'd1, 64'h7, 4'hF, 64'h0);
    step();
    rd(4'd1, 4'hF);
    chk("ins_stat_sticky", 64'(wbi.Stat), 64'h2);
    chk("ins_r1", wbi.d_rvalA, 64'h0);
    chk("ins_icount", wbi.icount, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wback_regfile.md
# wback_regfile

Writeback stage and architectural register file for the pipelined Y86-64 core. Consumes the W pipeline register outputs, commits valE/valM to the 15 program registers on the rising clock edge, serves the two combinational decode read ports, and maintains the sticky processor status, the halt flag and a retired-instruction counter.

## Interface

Parameters:
- none; widths are fixed by the Y86-64 ISA.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- W_stat  in  2  status of the instruction in W: 00 AOK, 01 HLT, 10 ADR, 11 INS.
- W_icode  in  4  icode in W; 4'h1 (nop/bubble) and 4'h0 (halt) are relevant here.
- W_valE  in  64  ALU result.
- W_valM  in  64  memory read result.
- W_dstE  in  4  destination for valE; 4'hF = RNONE.
- W_dstM  in  4  destination for valM; 4'hF = RNONE.
- d_srcA  in  4  decode read address A; 4'hF = RNONE.
- d_srcB  in  4  decode read address B; 4'hF = RNONE.
- d_rvalA  out  64  contents of register d_srcA; 0 when d_srcA is RNONE.
- d_rvalB  out  64  contents of register d_srcB; 0 when d_srcB is RNONE.
- Stat  out  2  architectural processor status.
- halted  out  1  high once a non-AOK status has retired.
- icount  out  64  number of retired instructions.

## Operation

- Storage: 15 x 64-bit registers, indices 0-14 (rax..r14). Index 15 is not stored; writes to it are dropped.
- Commit enable: commit = (W_stat == AOK) and not halted.
- When commit is high:
  - W_dstE != F: reg[W_dstE] <= W_valE.
  - W_dstM != F: reg[W_dstM] <= W_valM.
  - W_dstE == W_dstM != F: W_valM wins; a single write of W_valM (popq %rsp rule).
- When commit is low, no register changes regardless of dst fields.
- Status: while not halted, Stat <= W_stat every cycle a non-AOK stat arrives. halted <= 1 on the same edge. After that Stat and halted are frozen until reset.
- Retire counter, while not halted:
  - icount += 1 when (W_stat == AOK and W_icode != 4'h1), or when W_stat == HLT.
  - ADR/INS instructions and bubbles are not counted.
  - 64-bit wrap from all-ones to 0 with no flag.
- Read ports are purely combinational from the register array. There is no internal write-to-read bypass; the forwarding logic in decode covers W-stage values.

## Timing

- Reset (async assert, any time, including mid-write): all 15 registers = 0, Stat = 00 (AOK), halted = 0, icount = 0. d_rvalA/B reflect the cleared array immediately.
- Deassertion is synchronised by the caller. The first posedge after rst_n rises may commit.
- Write latency: a value presented in W at edge N is visible on d_rvalA/B after edge N (same-cycle read returns the old value).
- Status latency: a non-AOK W_stat at edge N gives Stat/halted valid after edge N. The instruction at edge N is itself not committed. Any instruction arriving at edge N+1 or later is blocked.
- W inputs held constant across edges (W stalled) re-commit the same values. This is idempotent for registers, but icount increments per edge; the pipeline control must bubble or hold W_icode at nop during stalls.

## Test plan

- Reset then read: rst_n low, d_srcA=0, d_srcB=14 -> d_rvalA=0, d_rvalB=0, Stat=00, halted=0, icount=0.
- Dual write: W_stat=AOK, icode=5, dstE=3 valE=0x11, dstM=7 valM=0x22, one edge -> reg3=0x11, reg7=0x22, icount=1. Reading on the same cycle before the edge returns 0.
- Write collision: dstE=dstM=4, valE=0xAAAA, valM=0xBBBB -> reg4=0xBBBB. RNONE on both ports -> no register changes, icount still increments.
- Halt freeze: HLT in W -> Stat=01, halted=1, icount incremented. Next edge, AOK instr with dstE=2 valE=5 -> reg2 unchanged, icount unchanged.
- ADR/INS: W_stat=10 with dstM=1 valM=9 -> reg1 unchanged, Stat=10, halted=1, icount unchanged. A later W_stat=11 leaves Stat=10.
- Async reset mid-run: rst_n low between edges after several writes -> all outputs clear without waiting for clk.
